pk_cam: RTL and testbench

Sequential-search content-addressable store for account keys in the Pass-Keeper hardware wrapper. It sits directly beside the control FSM. The FSM writes key entries at its 4-bit flash/CAM address during boot-load and after a new password is stored. It then issues a lookup and consumes `match`/`match_addr` to decide between the matched (decrypt) and not-matched (encrypt/store) paths. The search scans one entry per clock and returns the lowest-index hit.

---
 rtl/pk_cam.sv | 127 ++++++++++++
 tb/tb_pk_cam.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pk_cam.sv
// Sequential-search key CAM for the Pass-Keeper wrapper.
// Scans one entry per clock and reports the lowest-index hit.
module pk_cam #(
  parameter int KEY_W  = 128,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [KEY_W-1:0]  wr_key,
  input  logic              inv_en,
  input  logic              search_start,
  input  logic [KEY_W-1:0]  search_key,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic [ADDR_W-1:0] match_addr,
  output logic [ADDR_W:0]   count,
  output logic              full
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CAP  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE  = (ADDR_W + 1)'(1);

  logic [KEY_W-1:0]  keys [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [KEY_W-1:0]  key_q;
  logic [ADDR_W-1:0] idx;
  state_t            state;

  logic            hit;
  logic            wr_new;
  logic            inv_hit;
  logic [ADDR_W:0] count_nxt;

  assign hit     = valid[idx] && (keys[idx] == key_q);
  assign wr_new  = wr_en && !valid[wr_addr];
  assign inv_hit = !wr_en && inv_en && valid[wr_addr];

  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      wr_new:  count_nxt = count + ONE;
      inv_hit: count_nxt = count - ONE;
      default: count_nxt = count;
    endcase
  end

  // Write port has priority over invalidate on the same address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      count <= '0;
      full  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        keys[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        keys[wr_addr]  <= wr_key;
        valid[wr_addr] <= 1'b1;
      end else if (inv_en) begin
        valid[wr_addr] <= 1'b0;
      end
      count <= count_nxt;
      full  <= (count_nxt == CAP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      key_q      <= '0;
      idx        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      match      <= 1'b0;
      match_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (search_start) begin
            key_q      <= search_key;
            idx        <= '0;
            match      <= 1'b0;
            match_addr <= '0;
            busy       <= 1'b1;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            match      <= 1'b1;
            match_addr <= idx;
            done       <= 1'b1;
            state      <= DONE;
          end else if (idx == LAST) begin
            match      <= 1'b0;
            match_addr <= '0;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pk_cam.sv
// Directed plus randomized bench for pk_cam.
// Expected results come from a flat array model of the CAM.
module tb_pk_cam;

  localparam int KW = 128;
  localparam int DP = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [KW-1:0] wr_key;
  logic          inv_en;
  logic          search_start;
  logic [KW-1:0] search_key;
  logic          busy;
  logic          done;
  logic          match;
  logic [AW-1:0] match_addr;
  logic [AW:0]   count;
  logic          full;

  int errors = 0;
  int checks = 0;

  logic [KW-1:0] m_key [DP];
  bit            m_val [DP];
  logic [KW-1:0] pool  [8];

  pk_cam #(.KEY_W(KW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_key(wr_key),
    .inv_en(inv_en),
    .search_start(search_start), .search_key(search_key),
    .busy(busy), .done(done), .match(match),
    .match_addr(match_addr), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DP; i++) if (m_val[i]) n++;
    return n;
  endfunction

  function automatic int m_find(input logic [KW-1:0] k);
    for (int i = 0; i < DP; i++)
      if (m_val[i] && m_key[i] == k) return i;
    return -1;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < DP; i++) begin
      m_key[i] = '0;
      m_val[i] = 1'b0;
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(m_count()));
    chk({tag, ".full"}, 32'(full), 32'(m_count() == DP));
  endtask

  task automatic op(input bit w, input bit inv, input int a,
                    input logic [KW-1:0] k);
    wr_en   = w;
    inv_en  = inv;
    wr_addr = AW'(a);
    wr_key  = k;
    tick();
    wr_en  = 1'b0;
    inv_en = 1'b0;
    if (w) begin
      m_key[a] = k;
      m_val[a] = 1'b1;
    end else if (inv) begin
      m_val[a] = 1'b0;
    end
  endtask

  // Returns cycles from the accepting edge until done is seen
  task automatic search(input logic [KW-1:0] k, input int wr_at,
                        input int wa, input logic [KW-1:0] wk,
                        input int ign_at, output int lat);
    search_key   = k;
    search_start = 1'b1;
    tick();
    search_start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == wr_at) begin
        wr_en   = 1'b1;
        wr_addr = AW'(wa);
        wr_key  = wk;
      end
      if (lat == ign_at) begin
        search_start = 1'b1;
        search_key   = pool[0];
      end
      tick();
      wr_en        = 1'b0;
      search_start = 1'b0;
      lat++;
    end
  endtask

  task automatic expect_result(input string tag, input int lat,
                               input int exp_idx);
    int el;
    el = (exp_idx < 0) ? DP + 1 : exp_idx + 2;
    chk({tag, ".lat"}, 32'(lat), 32'(el));
    chk({tag, ".busy_at_done"}, 32'(busy), 32'd1);
    chk({tag, ".match"}, 32'(match), 32'(exp_idx >= 0));
    chk({tag, ".addr"}, 32'(match_addr),
        32'((exp_idx < 0) ? 0 : exp_idx));
    tick();
    chk({tag, ".busy_after"}, 32'(busy), 32'd0);
    chk({tag, ".done_after"}, 32'(done), 32'd0);
    chk({tag, ".hold"}, 32'(match), 32'(exp_idx >= 0));
  endtask

  initial begin
    int lat;
    int e;
    logic [KW-1:0] k;

    rst = 1'b1;
    wr_en = 1'b0; inv_en = 1'b0; wr_addr = '0; wr_key = '0;
    search_start = 1'b0; search_key = '0;
    m_clear();
    for (int i = 0; i < 8; i++)
      pool[i] = {$urandom, $urandom, $urandom, $urandom};
    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.match", 32'(match), 32'd0);
    chk("rst.addr", 32'(match_addr), 32'd0);
    chk_cnt("rst");

    search(KW'(8'hA5), -1, 0, '0, -1, lat);
    expect_result("empty", lat, -1);
    chk_cnt("empty");

    op(1, 0, 3, KW'(8'h11));
    op(1, 0, 9, KW'(8'h22));
    search(KW'(8'h22), -1, 0, '0, -1, lat);
    expect_result("hit9", lat, 9);
    chk_cnt("hit9");

    op(1, 0, 2, KW'(8'h33));
    op(1, 0, 7, KW'(8'h33));
    search(KW'(8'h33), -1, 0, '0, -1, lat);
    expect_result("lowest", lat, 2);

    for (int i = 0; i < DP; i++) op(1, 0, i, KW'(32'h100 + i));
    chk_cnt("fill");
    chk("fill.full", 32'(full), 32'd1);
    op(0, 1, 5, '0);
    chk_cnt("inv5");
    chk("inv5.count", 32'(count), 32'd15);
    op(0, 1, 5, '0);
    chk_cnt("inv5_again");
    search(KW'(32'h105), -1, 0, '0, -1, lat);
    expect_result("inv_miss", lat, -1);
    op(1, 1, 5, KW'(32'h105));
    chk_cnt("wr_inv");
    chk("wr_inv.count", 32'(count), 32'd16);

    search(KW'(8'h44), 3, 10, KW'(8'h44), -1, lat);
    m_key[10] = KW'(8'h44);
    expect_result("wr_ahead", lat, 10);
    op(1, 0, 10, KW'(32'h10A));
    search(KW'(8'h44), 3, 1, KW'(8'h44), 6, lat);
    m_key[1] = KW'(8'h44);
    expect_result("wr_behind", lat, -1);

    search(KW'(32'h100), -1, 0, '0, -1, lat);
    expect_result("pre_rst", lat, 0);
    search_key   = KW'(32'h10F);
    search_start = 1'b1;
    tick();
    search_start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    #1;
    m_clear();
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.match", 32'(match), 32'd0);
    chk_cnt("midrst");
    tick();
    rst = 1'b0;
    tick();
    search(KW'(32'h105), -1, 0, '0, -1, lat);
    expect_result("post_rst", lat, -1);

    for (int n = 0; n < 60; n++) begin
      int sel;
      int a;
      sel = int'($urandom_range(0, 9));
      a   = int'($urandom_range(0, DP - 1));
      k   = pool[$urandom_range(0, 7)];
      if (sel < 5) begin
        op(1, sel == 4, a, k);
        chk_cnt("rnd_wr");
      end else if (sel < 7) begin
        op(0, 1, a, '0);
        chk_cnt("rnd_inv");
      end else begin
        e = m_find(k);
        search(k, -1, 0, '0, -1, lat);
        expect_result("rnd_srch", lat, e);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
